// File: rtl/down_count_ctrl.sv
// ---------------------------------------------------------------------------
// down_count_ctrl
//
// Loadable down-counter with a small control FSM (IDLE / RUN / PAUSE / DONE).
// A start pulse loads load_val and counts down to zero one step per clock.
// At zero the block either reloads (auto_reload=1) or parks in DONE.
// pause freezes the count, and abort returns the block to IDLE.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   begin a countdown from load_val (honoured in IDLE/DONE)
//   pause        in   level; freezes the count while in RUN/PAUSE
//   abort        in   return to IDLE with count 0 (highest priority)
//   auto_reload  in   at terminal count, reload load_val instead of stopping
//   load_val     in   [WIDTH-1:0] countdown start value
//   count        out  [WIDTH-1:0] current count (register)
//   state        out  [1:0] IDLE=0, RUN=1, PAUSE=2, DONE=3 (register)
//   busy         out  state is RUN or PAUSE
//   tc           out  state is RUN and count is 0
//   done         out  state is DONE
// ---------------------------------------------------------------------------
module down_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             w_count_zero;

    assign w_count_zero = (r_count == '0);

    // Priority on every edge: abort, then pause/resume, then start, then
    // the countdown itself. load_val and auto_reload are only looked at on
    // the edges that actually use them (start, or terminal count in RUN).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_count <= load_val;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        // Freeze, even at terminal count.
                        r_state <= ST_PAUSE;
                    end else if (!w_count_zero) begin
                        r_count <= r_count - ONE;
                    end else if (auto_reload) begin
                        r_count <= load_val;
                    end else begin
                        // Count is already 0; it simply stays there.
                        r_state <= ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    // Resume without touching the count; the next
                    // decrement happens on the edge after this one.
                    if (!pause) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_count <= load_val;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Status flags decode registered state/count only.
    assign count = r_count;
    assign state = r_state;
    assign busy  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign tc    = (r_state == ST_RUN) && w_count_zero;
    assign done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_down_count_ctrl.sv
module tb_down_count_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, pause, abort, auto_reload;
    logic [3:0] load_val;
    logic [3:0] count;
    logic [1:0] state;
    logic       busy, tc, done;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: state code (0..3) and remaining count as plain ints.
    int m_state = 0;
    int m_count = 0;

    always #5 clk = ~clk;

    down_count_ctrl #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .count       (count),
        .state       (state),
        .busy        (busy),
        .tc          (tc),
        .done        (done)
    );

    typedef struct {
        logic       s, p, a, ar;
        logic [3:0] lv;
        int         ec;
        int         es;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic p, input logic a, input logic ar,
                       input logic [3:0] lv, input int ec, input int es);
        vec_t v;
        v.s = s; v.p = p; v.a = a; v.ar = ar; v.lv = lv; v.ec = ec; v.es = es;
        tbl.push_back(v);
    endtask

    // Behavioural rules: abort > pause/resume > start > countdown.
    task automatic model_step(input logic s, input logic p, input logic a,
                              input logic ar, input logic [3:0] lv);
        if (a) begin
            m_state = 0; m_count = 0;
        end else if (m_state == 0 || m_state == 3) begin
            if (s) begin m_state = 1; m_count = int'(lv); end
        end else if (m_state == 1) begin
            if (p)                m_state = 2;
            else if (m_count > 0) m_count = m_count - 1;
            else if (ar)          m_count = int'(lv);
            else                  m_state = 3;
        end else begin
            if (!p) m_state = 1;
        end
    endtask

    task automatic check_exp(input string name, input int ec, input int es);
        logic [8:0] got, exp;
        logic [3:0] ec4;
        logic [1:0] es2;
        ec4 = ec[3:0];
        es2 = es[1:0];
        got = {count, state, busy, tc, done};
        exp = {ec4, es2, (es == 1 || es == 2), (es == 1 && ec == 0), (es == 3)};
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got count=%0d state=%0d busy=%b tc=%b done=%b, expected count=%0d state=%0d busy=%b tc=%b done=%b",
                      name, count, state, busy, tc, done, ec4, es2, exp[2], exp[1], exp[0]);
    endtask

    task automatic step(input logic s, input logic p, input logic a,
                        input logic ar, input logic [3:0] lv);
        start = s; pause = p; abort = a; auto_reload = ar; load_val = lv;
        @(posedge clk);
        model_step(s, p, a, ar, lv);
        #1;
    endtask

    initial begin
        string nm;
        logic rs, rp, ra, rar;
        logic [3:0] rlv;

        reset = 1'b0; start = 0; pause = 0; abort = 0; auto_reload = 0; load_val = 4'd0;
        #20;
        check_exp("reset_state", 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // start lv=5, no reload: 5..0, then DONE held
        add(1,0,0,0,5, 5,1);
        add(0,0,0,0,12,4,1); add(0,0,0,0,12,3,1); add(0,0,0,0,1,2,1);
        add(0,0,0,0,7, 1,1); add(0,0,0,0,7, 0,1);
        add(0,0,0,0,7, 0,3); add(0,0,0,0,7, 0,3);
        // restart from DONE with lv=2
        add(1,0,0,0,2, 2,1); add(0,0,0,0,9,1,1); add(0,0,0,0,9,0,1); add(0,0,0,0,9,0,3);
        // lv=0: tc in first RUN cycle, then DONE
        add(1,0,0,0,0, 0,1); add(0,0,0,0,0,0,3);
        // lv=3 auto_reload: 3,2,1,0,3,2,1,0,3 then abort
        add(1,0,0,1,3, 3,1); add(0,0,0,1,3,2,1); add(0,0,0,1,3,1,1); add(0,0,0,1,3,0,1);
        add(0,0,0,1,3, 3,1); add(0,0,0,1,3,2,1); add(0,0,0,1,3,1,1); add(0,0,0,1,3,0,1);
        add(0,0,0,1,3, 3,1); add(0,0,1,1,3,0,0);
        // lv=9, pause 3 cycles at 6, resume, start ignored, abort at 4
        add(1,0,0,0,9, 9,1); add(0,0,0,0,9,8,1); add(0,0,0,0,9,7,1); add(0,0,0,0,9,6,1);
        add(0,1,0,0,9, 6,2); add(1,1,0,0,2,6,2); add(0,1,0,0,9,6,2);
        add(0,0,0,0,9, 6,1); add(1,0,0,0,15,5,1); add(1,0,0,0,15,4,1);
        add(1,0,1,0,15,0,0);
        // lv=0 with auto_reload: tc every RUN cycle
        add(1,0,0,1,0, 0,1); add(0,0,0,1,0,0,1); add(0,0,0,1,0,0,1); add(0,0,1,1,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, tbl[i].p, tbl[i].a, tbl[i].ar, tbl[i].lv);
            nm = $sformatf("vec%0d", i);
            check_exp(nm, tbl[i].ec, tbl[i].es);
        end

        // Pause while at terminal count: tc drops in PAUSE, returns on resume.
        step(1,0,0,0,1); check_exp("pz_load", 1, 1);
        step(0,0,0,0,1); check_exp("pz_tc", 0, 1);
        step(0,1,0,0,1); check_exp("pz_pause0", 0, 2);
        step(0,1,0,0,1); check_exp("pz_pause1", 0, 2);
        step(0,0,0,0,1); check_exp("pz_resume", 0, 1);
        step(0,0,0,0,1); check_exp("pz_done", 0, 3);

        // Asynchronous reset mid-count, visible before the next edge.
        step(1,0,0,0,8); check_exp("ar_load", 8, 1);
        step(0,0,0,0,8); check_exp("ar_dec", 7, 1);
        #2 reset = 1'b0;
        #1 check_exp("async_rst", 0, 0);
        m_state = 0; m_count = 0;
        @(negedge clk);
        check_exp("rst_hold", 0, 0);
        reset = 1'b1;
        step(1,0,0,0,7); check_exp("post_rst_load", 7, 1);
        step(0,0,0,0,3); check_exp("post_rst_dec", 6, 1);

        // Random stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            rs  = ($urandom % 4) == 0;
            rp  = ($urandom % 5) == 0;
            ra  = ($urandom % 30) == 0;
            rar = ($urandom % 2) == 1;
            rlv = 4'($urandom % 16);
            step(rs, rp, ra, rar, rlv);
            nm = $sformatf("rand%0d", i);
            check_exp(nm, m_count, m_state);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/down_count_ctrl.md
DOWN_COUNT_CTRL -- requirements
Module: down_count_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, width of the down-count value and of the load value.
REQ-002 clk  input  1  rising-edge system clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  when idle or done, begins a countdown from load_val.
REQ-005 pause  input  1  level; when high in RUN the count is frozen.
REQ-006 abort  input  1  cancels any activity and returns the block to IDLE.
REQ-007 auto_reload  input  1  when high, terminal count reloads load_val instead of stopping.
REQ-008 load_val  input  WIDTH  countdown start value.
REQ-009 count  output  WIDTH  current down-count value, registered.
REQ-010 state  output  2  current FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-011 busy  output  1  high in RUN or PAUSE.
REQ-012 tc  output  1  terminal-count flag, high exactly while state==RUN and count==0.
REQ-013 done  output  1  high while state==DONE.

Function
REQ-014 All state and count registers SHALL update only on the rising edge of clk, except during reset.
REQ-015 Control priority on every edge SHALL be: abort > pause/resume > start > countdown.
REQ-016 IDLE: count holds 0; start=1 loads count<=load_val and moves to RUN on the same edge.
REQ-017 RUN, count!=0, pause=0: count<=count-1 each edge.
REQ-018 RUN, count==0, pause=0, auto_reload=1: count<=load_val; stay in RUN.
REQ-019 RUN, count==0, pause=0, auto_reload=0: move to DONE; count stays 0.
REQ-020 Latency: for a start at edge k with load_val=N, tc SHALL be high in the cycle after edge k+N, and DONE SHALL be entered at edge k+N+1.
REQ-021 RUN with pause=1: move to PAUSE and hold count, including when count==0.
REQ-022 PAUSE with pause=1: hold count; tc=0.
REQ-023 PAUSE with pause=0: return to RUN with count unchanged; decrementing resumes on the following edge.
REQ-024 start SHALL be ignored in RUN and PAUSE.
REQ-025 DONE: count holds 0; start=1 loads load_val and moves to RUN.
REQ-026 DONE without start: remain in DONE indefinitely.
REQ-027 abort=1 in any state SHALL set state to IDLE and count to 0 on the next edge.
REQ-028 load_val SHALL be sampled only on a start edge or a reload edge.
REQ-029 Changes to load_val at any other time SHALL not affect count.
REQ-030 load_val=0 at start: tc is high in the first RUN cycle.
REQ-031 load_val=0 with auto_reload=1: tc is high every RUN cycle.
REQ-032 Count arithmetic SHALL be unsigned modulo 2^WIDTH.
REQ-033 Count SHALL never decrement below 0 (no wrap to all-ones).
REQ-034 auto_reload SHALL be sampled only on the edge where count==0 in RUN.
REQ-035 busy, tc, done and state SHALL be decoded from registered state and count only, with no dependence on inputs.

Reset
REQ-036 While reset=0: state=IDLE, count=0, busy=0, tc=0, done=0, independent of clk.
REQ-037 Asserting reset mid-countdown SHALL take effect immediately.
REQ-038 After reset is released, the first start SHALL begin a fresh countdown from load_val.

Verification
REQ-039 Reset 20 ns, then start with load_val=5, auto_reload=0 -> count 5,4,3,2,1,0; tc high one cycle at 0; then state=DONE, done=1.
REQ-040 load_val=3, auto_reload=1 -> count 3,2,1,0,3,2,1,0,...; tc high once per 4 cycles; never reaches DONE.
REQ-041 load_val=9; pause high for 3 cycles while count=6 -> count holds 6, state=PAUSE, busy=1; after release, count goes 6,5,...
REQ-042 abort while count=4 in RUN -> next edge state=IDLE, count=0; start held in RUN has no effect.
REQ-043 load_val=0 start -> tc high for the first RUN cycle, then DONE.
REQ-044 start again from DONE with load_val=2 -> count 2,1,0, then DONE.
REQ-045 reset pulled low asynchronously mid-count -> all outputs 0 and state=IDLE before the next clk edge.
